// File: rtl/ring_buffer_monitor_if.sv
// ring_buffer_monitor_if
// Groups the signals a ring-buffer monitor observes and reports.
//   master : side that owns the buffer (drives capture/read nets, reads results)
//   slave  : the monitor (observes capture/read nets, drives results)
// Signals:
//   listen, strobe, din   - buffer capture enable, DQS-derived strobe, capture data
//   readPtr, dout         - buffer read address and read data
//   mismatch, error       - one-cycle compare-fail pulse, sticky error flag
//   error_count           - saturating mismatch count
//   write_count           - wrapping capture-event count
//   wptr                  - shadow write pointer (next slot to be written)
//   expected, bad_ptr     - golden value and read address at the last mismatch
interface ring_buffer_monitor_if #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic          listen;
    logic          strobe;
    logic [DW-1:0] din;
    logic [PW-1:0] readPtr;
    logic [DW-1:0] dout;

    logic          mismatch;
    logic          error;
    logic [15:0]   error_count;
    logic [15:0]   write_count;
    logic [PW-1:0] wptr;
    logic [DW-1:0] expected;
    logic [PW-1:0] bad_ptr;

    modport master (
        output listen, strobe, din, readPtr, dout,
        input  mismatch, error, error_count, write_count, wptr, expected, bad_ptr
    );

    modport slave (
        input  listen, strobe, din, readPtr, dout,
        output mismatch, error, error_count, write_count, wptr, expected, bad_ptr
    );
endinterface

// File: rtl/ring_buffer_monitor.sv
// ring_buffer_monitor
// Passive checker shadowing an 8-entry read-capture ring buffer. Keeps a golden copy of
// every captured entry and flags read-port data that disagrees with it.
// Ports:
//   clk   - controller clock, all state updates on its rising edge
//   reset - asynchronous active-high reset
//   mon   - ring_buffer_monitor_if.slave (capture/read nets in, results out)
module ring_buffer_monitor #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 8
) (
    input logic                 clk,
    input logic                 reset,
    ring_buffer_monitor_if.slave mon
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic                 strobe_q;
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DW-1:0]        shadow_q [DEPTH];
    logic [15:0]          write_count_q, write_count_d;
    // Slot written in the previous cycle, used for read blanking.
    logic                 last_vld_q;
    logic [PW-1:0]        last_ptr_q;

    logic                 mismatch_q, mismatch_d;
    logic                 error_q, error_d;
    logic [15:0]          error_count_q, error_count_d;
    logic [DW-1:0]        expected_q, expected_d;
    logic [PW-1:0]        bad_ptr_q, bad_ptr_d;

    logic                 cap;
    logic                 blank;
    logic                 cmp_en;
    logic                 miss;
    logic [DW-1:0]        rd_gold;

    always_comb begin
        // Either strobe edge is a capture event.
        cap     = mon.listen & (mon.strobe ^ strobe_q);
        rd_gold = shadow_q[mon.readPtr];

        // The real buffer writes asynchronously in the strobe domain, so the slot being
        // written now and the one written last cycle may not be settled on the read port.
        blank  = (cap && (mon.readPtr == wptr_q)) ||
                 (last_vld_q && (mon.readPtr == last_ptr_q));
        cmp_en = valid_q[mon.readPtr] && !blank;
        // Case inequality so X/Z on dout is reported as a mismatch in simulation.
        miss   = cmp_en && (mon.dout !== rd_gold);

        wptr_d        = wptr_q;
        valid_d       = valid_q;
        write_count_d = write_count_q;
        if (cap) begin
            wptr_d          = wptr_q + PW'(1);
            valid_d[wptr_q] = 1'b1;
            write_count_d   = write_count_q + 16'd1;
        end

        mismatch_d    = miss;
        error_d       = error_q;
        error_count_d = error_count_q;
        expected_d    = expected_q;
        bad_ptr_d     = bad_ptr_q;
        if (miss) begin
            error_d    = 1'b1;
            expected_d = rd_gold;
            bad_ptr_d  = mon.readPtr;
            if (error_count_q != 16'hFFFF) begin
                error_count_d = error_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q      <= 1'b0;
            wptr_q        <= '0;
            valid_q       <= '0;
            write_count_q <= '0;
            last_vld_q    <= 1'b0;
            last_ptr_q    <= '0;
            mismatch_q    <= 1'b0;
            error_q       <= 1'b0;
            error_count_q <= '0;
            expected_q    <= '0;
            bad_ptr_q     <= '0;
        end else begin
            strobe_q      <= mon.strobe;
            wptr_q        <= wptr_d;
            valid_q       <= valid_d;
            write_count_q <= write_count_d;
            last_vld_q    <= cap;
            last_ptr_q    <= wptr_q;
            mismatch_q    <= mismatch_d;
            error_q       <= error_d;
            error_count_q <= error_count_d;
            expected_q    <= expected_d;
            bad_ptr_q     <= bad_ptr_d;
        end
    end

    // Shadow data is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (cap) begin
            shadow_q[wptr_q] <= mon.din;
        end
    end

    assign mon.mismatch    = mismatch_q;
    assign mon.error       = error_q;
    assign mon.error_count = error_count_q;
    assign mon.write_count = write_count_q;
    assign mon.wptr        = wptr_q;
    assign mon.expected    = expected_q;
    assign mon.bad_ptr     = bad_ptr_q;
endmodule

// File: tb/tb_ring_buffer_monitor.sv
module tb_ring_buffer_monitor;
    logic clk;
    logic reset;

    ring_buffer_monitor_if #(.DW(16), .DEPTH(8)) mon_if ();

    ring_buffer_monitor #(.DW(16), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mon_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [15:0] gold [8];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " mismatch"}, 32'(mon_if.mismatch), 32'd0);
        check_eq({tag, " error"}, 32'(mon_if.error), 32'd0);
        check_eq({tag, " error_count"}, 32'(mon_if.error_count), 32'd0);
        check_eq({tag, " write_count"}, 32'(mon_if.write_count), 32'd0);
        check_eq({tag, " wptr"}, 32'(mon_if.wptr), 32'd0);
        check_eq({tag, " expected"}, 32'(mon_if.expected), 32'd0);
        check_eq({tag, " bad_ptr"}, 32'(mon_if.bad_ptr), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        mon_if.listen  = 1'b0;
        mon_if.strobe  = 1'b0;
        mon_if.din     = 16'h0;
        mon_if.readPtr = 3'd0;
        mon_if.dout    = 16'h0;
        for (int i = 0; i < 8; i++) gold[i] = 16'h0;

        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // Fill and wrap: 10 captures, dout kept equal to the pre-edge golden slot.
        mon_if.listen = 1'b1;
        for (int n = 0; n < 10; n++) begin
            mon_if.din    = 16'(16'h1000 + n);
            mon_if.strobe = ~mon_if.strobe;
            mon_if.dout   = gold[mon_if.readPtr];
            step();
            gold[n % 8] = 16'(16'h1000 + n);
        end
        check_eq("fill wptr", 32'(mon_if.wptr), 32'd2);
        check_eq("fill write_count", 32'(mon_if.write_count), 32'd10);
        check_eq("fill no mismatch", 32'(mon_if.error_count), 32'd0);

        // Clean read-back sweep.
        for (int p = 0; p < 8; p++) begin
            mon_if.readPtr = 3'(p);
            mon_if.dout    = gold[p];
            step();
            check_eq($sformatf("sweep mismatch p%0d", p), 32'(mon_if.mismatch), 32'd0);
        end
        check_eq("sweep error_count", 32'(mon_if.error_count), 32'd0);
        check_eq("sweep error", 32'(mon_if.error), 32'd0);

        // Corruption at slot 3.
        mon_if.readPtr = 3'd3;
        mon_if.dout    = 16'h1003 ^ 16'h0001;
        step();
        check_eq("corrupt mismatch", 32'(mon_if.mismatch), 32'd1);
        check_eq("corrupt error", 32'(mon_if.error), 32'd1);
        check_eq("corrupt error_count", 32'(mon_if.error_count), 32'd1);
        check_eq("corrupt bad_ptr", 32'(mon_if.bad_ptr), 32'd3);
        check_eq("corrupt expected", 32'(mon_if.expected), 32'h1003);
        mon_if.dout = 16'h1003;
        step();
        check_eq("corrupt pulse ends", 32'(mon_if.mismatch), 32'd0);
        check_eq("corrupt error sticky", 32'(mon_if.error), 32'd1);

        // Slot 0 was overwritten by the wrap and must hold 0x1008.
        mon_if.readPtr = 3'd0;
        mon_if.dout    = 16'h1000;
        step();
        check_eq("wrap mismatch", 32'(mon_if.mismatch), 32'd1);
        check_eq("wrap expected", 32'(mon_if.expected), 32'h1008);
        check_eq("wrap bad_ptr", 32'(mon_if.bad_ptr), 32'd0);
        check_eq("wrap error_count", 32'(mon_if.error_count), 32'd2);
        mon_if.dout = 16'h1008;
        step();

        // Gating: strobe toggles with listen low are ignored.
        mon_if.listen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            mon_if.strobe = ~mon_if.strobe;
            step();
        end
        check_eq("gate wptr", 32'(mon_if.wptr), 32'd2);
        check_eq("gate write_count", 32'(mon_if.write_count), 32'd10);
        mon_if.listen = 1'b1;
        step();
        check_eq("listen rise no event", 32'(mon_if.write_count), 32'd10);

        // Blanking: read the slot being written, then the slot just written.
        mon_if.din     = 16'h2222;
        mon_if.strobe  = ~mon_if.strobe;
        mon_if.readPtr = 3'd2;
        mon_if.dout    = 16'hBAD0;
        step();
        check_eq("blank cur mismatch", 32'(mon_if.mismatch), 32'd0);
        check_eq("blank wptr", 32'(mon_if.wptr), 32'd3);
        check_eq("blank write_count", 32'(mon_if.write_count), 32'd11);
        step();
        check_eq("blank prev mismatch", 32'(mon_if.mismatch), 32'd0);
        step();
        check_eq("post-blank mismatch", 32'(mon_if.mismatch), 32'd1);
        check_eq("post-blank expected", 32'(mon_if.expected), 32'h2222);
        check_eq("post-blank bad_ptr", 32'(mon_if.bad_ptr), 32'd2);
        check_eq("post-blank error_count", 32'(mon_if.error_count), 32'd3);

        // Asynchronous reset mid-cycle.
        #2;
        reset         = 1'b1;
        mon_if.strobe = 1'b0;
        #1;
        check_all_zero("async reset");
        step();
        reset = 1'b0;

        // Unwritten slot: no compare.
        mon_if.readPtr = 3'd5;
        mon_if.dout    = 16'hDEAD;
        step();
        check_eq("unwritten mismatch", 32'(mon_if.mismatch), 32'd0);

        // First post-reset capture lands in slot 0.
        mon_if.din     = 16'hABCD;
        mon_if.strobe  = 1'b1;
        mon_if.readPtr = 3'd0;
        mon_if.dout    = 16'h0000;
        step();
        check_eq("post-reset wptr", 32'(mon_if.wptr), 32'd1);
        check_eq("post-reset write_count", 32'(mon_if.write_count), 32'd1);
        step();
        check_eq("post-reset blank", 32'(mon_if.mismatch), 32'd0);
        step();
        check_eq("post-reset mismatch", 32'(mon_if.mismatch), 32'd1);
        check_eq("post-reset expected", 32'(mon_if.expected), 32'hABCD);
        check_eq("post-reset error_count", 32'(mon_if.error_count), 32'd1);

        // Saturation: 65,537 mismatches in total.
        for (int n = 0; n < 65536; n++) step();
        check_eq("sat error_count", 32'(mon_if.error_count), 32'hFFFF);
        check_eq("sat mismatch", 32'(mon_if.mismatch), 32'd1);
        check_eq("sat error", 32'(mon_if.error), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
